pc_fetch_controller: RTL and testbench

PC_FETCH_CONTROLLER -- requirements
Module: pc_fetch_controller

---
 rtl/pc_fetch_controller_pkg.sv | 24 ++
 rtl/pc_fetch_controller_increment.sv | 16 +
 rtl/pc_fetch_controller.sv | 119 +++++++++++
 tb/tb_pc_fetch_controller.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_controller_pkg.sv
// pc_fetch_controller_pkg
// Shared definitions for the instruction fetch controller: FSM state
// encoding, datapath widths and the default reset program counter.
// No ports.
package pc_fetch_controller_pkg;

  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 16;
  localparam int JUMP_W   = 26;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  // Branch offsets are signed word counts; widen to the address width.
  function automatic logic [ADDR_W-1:0] sext_offset(input logic [OFFSET_W-1:0] off);
    return {{(ADDR_W-OFFSET_W){off[OFFSET_W-1]}}, off};
  endfunction

endpackage

// File: rtl/pc_fetch_controller_increment.sv
// instruction_increment
// Sequential word-address increment used for the fall-through PC.
// Wraps modulo 2^32.
// Ports:
//   pc_i       - current word address
//   pc_plus1_o - pc_i + 1
module instruction_increment
  import pc_fetch_controller_pkg::*;
(
  input  logic [ADDR_W-1:0] pc_i,
  output logic [ADDR_W-1:0] pc_plus1_o
);

  assign pc_plus1_o = pc_i + {{(ADDR_W-1){1'b0}}, 1'b1};

endmodule

// File: rtl/pc_fetch_controller.sv
// pc_fetch_controller
// Fetches one instruction word at a time from instruction memory, holds it
// for decode, and advances the PC (sequential, branch or jump) when decode
// accepts the word.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no fetch in flight; waits for stall to drop
// REQ   | imem_req high at imem_addr = pc; waits for imem_ack
// HOLD  | instr_valid high; waits for instr_ready, then updates pc
//
// Ports:
//   clk, reset                  - system clock, synchronous active-high reset
//   stall                       - blocks the start of a new fetch
//   imem_req/imem_addr          - memory read request and word address
//   imem_ack/imem_data          - memory read completion and data
//   instr_valid/instr           - fetched word presented to decode
//   instr_ready                 - decode accepts the word (accept)
//   branch_taken/branch_offset  - PC-relative redirect, sampled at accept
//   jump/jump_target            - absolute redirect, sampled at accept
//   pc                          - current program counter
module pc_fetch_controller
  import pc_fetch_controller_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ack,
  input  logic [ADDR_W-1:0]   imem_data,
  output logic                instr_valid,
  output logic [ADDR_W-1:0]   instr,
  input  logic                instr_ready,
  input  logic                branch_taken,
  input  logic [OFFSET_W-1:0] branch_offset,
  input  logic                jump,
  input  logic [JUMP_W-1:0]   jump_target,
  output logic [ADDR_W-1:0]   pc
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] instr_q;
  logic              imem_req_q;
  logic              instr_valid_q;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] next_pc_d;

  instruction_increment u_inc (
    .pc_i       (pc_q),
    .pc_plus1_o (pc_plus1)
  );

  // Jump keeps the upper bits of the fall-through address and wins over
  // a simultaneous branch.
  always_comb begin
    next_pc_d = pc_plus1;
    if (jump) begin
      next_pc_d = {pc_plus1[ADDR_W-1:JUMP_W], jump_target};
    end else if (branch_taken) begin
      next_pc_d = pc_plus1 + sext_offset(branch_offset);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!stall) begin
            state_q    <= ST_REQ;
            imem_req_q <= 1'b1;
          end
        end
        ST_REQ: begin
          // stall is deliberately not looked at: an issued request completes.
          if (imem_ack) begin
            instr_q       <= imem_data;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
            state_q       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (instr_ready) begin
            pc_q          <= next_pc_d;
            instr_valid_q <= 1'b0;
            if (!stall) begin
              state_q    <= ST_REQ;
              imem_req_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_pc_fetch_controller.sv
module tb_pc_fetch_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic [31:0] pc;

  int checks = 0;
  int failures = 0;
  logic [31:0] model_pc;

  always #5 clk = ~clk;

  pc_fetch_controller #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_data     (imem_data),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_ready   (instr_ready),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .pc            (pc)
  );

  // Reference next-PC rule in plain 64-bit integer arithmetic, reduced mod 2^32.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input bit br,
                                           input logic [15:0] off, input bit j,
                                           input logic [25:0] tgt);
    longint p1;
    longint soff;
    p1 = (longint'(cur) + 1) % 64'h1_0000_0000;
    if (j) return 32'((p1 / 64'h400_0000) * 64'h400_0000 + longint'(tgt));
    if (br) begin
      soff = (off >= 16'h8000) ? longint'(off) - 65536 : longint'(off);
      return 32'((p1 + soff + 64'h1_0000_0000) % 64'h1_0000_0000);
    end
    return 32'(p1);
  endfunction

  task automatic scramble();
    branch_taken  = 1'($urandom_range(0, 1));
    branch_offset = 16'($urandom);
    jump          = 1'($urandom_range(0, 1));
    jump_target   = 26'($urandom);
  endtask

  // Drives one complete fetch starting from a cycle in which the DUT is in REQ,
  // and leaves the DUT in REQ again at the next address.
  task automatic do_fetch(input int ack_dly, input int rdy_dly, input bit stall_acc,
                          input bit br, input logic [15:0] off, input bit j,
                          input logic [25:0] tgt);
    logic [31:0] data;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== model_pc) begin
      failures++;
      $display("FAIL req_start req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, model_pc);
    end
    for (int i = 0; i < ack_dly; i++) begin
      imem_ack = 1'b0; imem_data = $urandom; stall = 1'($urandom_range(0, 1)); scramble();
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== model_pc || instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL req_wait req=%b addr=%h valid=%b expected 1/%h/0", imem_req, imem_addr, instr_valid, model_pc);
      end
    end
    data = $urandom;
    imem_ack = 1'b1; imem_data = data; stall = 1'($urandom_range(0, 1)); scramble();
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || instr !== data || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL capture valid=%b instr=%h req=%b expected 1/%h/0", instr_valid, instr, imem_req, data);
    end
    for (int i = 0; i < rdy_dly; i++) begin
      instr_ready = 1'b0; imem_ack = 1'($urandom_range(0, 1)); imem_data = $urandom;
      stall = 1'($urandom_range(0, 1)); scramble();
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || instr !== data || pc !== model_pc || imem_req !== 1'b0) begin
        failures++;
        $display("FAIL hold_wait valid=%b instr=%h pc=%h req=%b expected 1/%h/%h/0", instr_valid, instr, pc, imem_req, data, model_pc);
      end
    end
    instr_ready = 1'b1; branch_taken = br; branch_offset = off; jump = j; jump_target = tgt;
    stall = stall_acc; imem_ack = 1'($urandom_range(0, 1)); imem_data = $urandom;
    @(negedge clk);
    model_pc = ref_next(model_pc, br, off, j, tgt);
    instr_ready = 1'b0; imem_ack = 1'b0; scramble();
    checks++;
    if (pc !== model_pc || instr_valid !== 1'b0 || imem_req !== !stall_acc) begin
      failures++;
      $display("FAIL accept pc=%h valid=%b req=%b expected %h/0/%b", pc, instr_valid, imem_req, model_pc, !stall_acc);
    end
    if (stall_acc) begin
      for (int i = 0; i < 3; i++) begin
        stall = 1'b1; imem_ack = 1'($urandom_range(0, 1)); imem_data = $urandom; scramble();
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || pc !== model_pc || instr_valid !== 1'b0) begin
          failures++;
          $display("FAIL idle_stall req=%b pc=%h valid=%b expected 0/%h/0", imem_req, pc, instr_valid, model_pc);
        end
      end
      stall = 1'b0; imem_ack = 1'b0;
      @(negedge clk);
    end else begin
      stall = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; imem_ack = 1'b0; imem_data = '0; instr_ready = 1'b0;
    scramble();
    repeat (3) @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0 || instr !== 32'h0 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_state req=%b valid=%b pc=%h instr=%h expected 0/0/0/0", imem_req, instr_valid, pc, instr);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_release req=%b addr=%h expected 1/0", imem_req, imem_addr);
    end
    model_pc = 32'h0;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem_addr !== 32'(i)) begin
        failures++;
        $display("FAIL seq_addr got=%h expected=%h", imem_addr, 32'(i));
      end
      do_fetch(1, 0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
    end
  endtask

  task automatic test_branch();
    do_fetch(0, 0, 1'b0, 1'b1, 16'h000B, 1'b0, 26'h0);
    checks++;
    if (pc !== 32'h10) begin failures++; $display("FAIL branch_setup pc=%h expected=00000010", pc); end
    do_fetch(2, 1, 1'b0, 1'b1, 16'hFFFC, 1'b0, 26'h0);
    checks++;
    if (imem_addr !== 32'h0D) begin failures++; $display("FAIL branch_neg addr=%h expected=0000000d", imem_addr); end
    do_fetch(0, 0, 1'b0, 1'b1, 16'h0002, 1'b0, 26'h0);
    do_fetch(1, 2, 1'b0, 1'b1, 16'h0005, 1'b0, 26'h0);
    checks++;
    if (imem_addr !== 32'h16) begin failures++; $display("FAIL branch_pos addr=%h expected=00000016", imem_addr); end
  endtask

  task automatic test_wrap_stall();
    do_fetch(0, 0, 1'b0, 1'b1, 16'hFFE8, 1'b0, 26'h0);
    checks++;
    if (pc !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_setup pc=%h expected=ffffffff", pc); end
    do_fetch(1, 1, 1'b1, 1'b0, 16'h0, 1'b0, 26'h0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL wrap_resume req=%b addr=%h expected 1/00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_jump();
    do_fetch(0, 0, 1'b0, 1'b0, 16'h0, 1'b1, 26'h3FF_FFFF);
    checks++;
    if (pc !== 32'h03FF_FFFF) begin failures++; $display("FAIL jump_low pc=%h expected=03ffffff", pc); end
    do_fetch(0, 0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
    do_fetch(0, 0, 1'b0, 1'b1, 16'h000F, 1'b0, 26'h0);
    checks++;
    if (pc !== 32'h0400_0010) begin failures++; $display("FAIL jump_setup pc=%h expected=04000010", pc); end
    do_fetch(1, 0, 1'b0, 1'b1, 16'($urandom), 1'b1, 26'h000_0123);
    checks++;
    if (imem_addr !== 32'h0400_0123) begin failures++; $display("FAIL jump_priority addr=%h expected=04000123", imem_addr); end
  endtask

  task automatic test_delays();
    do_fetch(5, 3, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
    do_fetch(5, 3, 1'b0, 1'b1, 16'h0007, 1'b0, 26'h0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      do_fetch(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 16'($urandom),
               ($urandom_range(0, 3) == 0), 26'($urandom));
    end
  endtask

  task automatic test_reset_in_req();
    logic [31:0] junk;
    reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
    model_pc = 32'h0;
    do_fetch(0, 0, 1'b0, 1'b1, 16'h001F, 1'b0, 26'h0);
    checks++;
    if (imem_addr !== 32'h20) begin failures++; $display("FAIL rst_req_setup addr=%h expected=00000020", imem_addr); end
    junk = $urandom | 32'h1;
    reset = 1'b1; imem_ack = 1'b1; imem_data = junk;
    @(negedge clk);
    reset = 1'b0; imem_ack = 1'b0;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0 || instr !== 32'h0) begin
      failures++;
      $display("FAIL rst_in_req req=%b valid=%b pc=%h instr=%h expected 0/0/0/0", imem_req, instr_valid, pc, instr);
    end
    @(negedge clk);
    model_pc = 32'h0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL rst_req_resume req=%b addr=%h expected 1/0", imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_in_hold();
    do_fetch(0, 0, 1'b0, 1'b1, 16'h0040, 1'b0, 26'h0);
    imem_ack = 1'b1; imem_data = $urandom;
    @(negedge clk);
    imem_ack = 1'b0;
    reset = 1'b1; instr_ready = 1'b1; jump = 1'b1; jump_target = 26'($urandom_range(1, 1000));
    @(negedge clk);
    reset = 1'b0; instr_ready = 1'b0; jump = 1'b0;
    checks++;
    if (pc !== 32'h0 || instr_valid !== 1'b0 || instr !== 32'h0 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL rst_in_hold pc=%h valid=%b instr=%h req=%b expected 0/0/0/0", pc, instr_valid, instr, imem_req);
    end
    @(negedge clk);
    model_pc = 32'h0;
    do_fetch(0, 0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_wrap_stall();
    test_jump();
    test_delays();
    test_random();
    test_reset_in_req();
    test_reset_in_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
